// File: rtl/lcd_spi_write.sv
// Serialises one 9-bit LCD word (D/C + byte) onto a mode-0 SPI link, MSB first.
// One word is handled per request; a short CS-high gap follows each byte.
module lcd_spi_write #(
    parameter logic [3:0] SCLK_HALF = 4'd2,
    parameter logic [2:0] GAP_CYC   = 3'd2
) (
    input  logic       sys_clk_50MHz,
    input  logic       sys_rst,
    input  logic       en_write,
    input  logic [8:0] data,
    output logic       wr_done,
    output logic       busy,
    output logic       lcd_sclk,
    output logic       lcd_mosi,
    output logic       lcd_dc,
    output logic       lcd_cs
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        DONE  = 3'd3,
        GAP   = 3'd4
    } state_t;

    localparam logic [3:0] HALF_LAST = SCLK_HALF - 4'd1;
    // DONE already counts as the first gap clock, so GAP itself lasts GAP_CYC-1 clocks.
    localparam logic [2:0] GAP_LAST  = (GAP_CYC > 3'd1) ? (GAP_CYC - 3'd2) : 3'd0;

    state_t     state;
    logic [3:0] half_cnt;
    logic [2:0] bit_cnt;
    logic [2:0] gap_cnt;
    logic [7:0] shift_q;

    always_ff @(posedge sys_clk_50MHz or posedge sys_rst) begin
        if (sys_rst) begin
            state    <= IDLE;
            half_cnt <= 4'd0;
            bit_cnt  <= 3'd0;
            gap_cnt  <= 3'd0;
            shift_q  <= 8'd0;
            lcd_sclk <= 1'b0;
            lcd_mosi <= 1'b0;
            lcd_dc   <= 1'b0;
            lcd_cs   <= 1'b1;
            wr_done  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            wr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (en_write) begin
                        state    <= LOAD;
                        busy     <= 1'b1;
                        shift_q  <= data[7:0];
                        lcd_dc   <= data[8];
                        lcd_mosi <= data[7];
                        lcd_cs   <= 1'b0;
                        lcd_sclk <= 1'b0;
                    end
                end

                LOAD: begin
                    state    <= SHIFT;
                    half_cnt <= 4'd0;
                    bit_cnt  <= 3'd0;
                end

                SHIFT: begin
                    if (half_cnt == HALF_LAST) begin
                        half_cnt <= 4'd0;
                        if (!lcd_sclk) begin
                            lcd_sclk <= 1'b1;
                        end else begin
                            // Falling edge: next bit goes out at the start of the low phase.
                            lcd_sclk <= 1'b0;
                            if (bit_cnt == 3'd7) begin
                                state   <= DONE;
                                wr_done <= 1'b1;
                                lcd_cs  <= 1'b1;
                            end else begin
                                bit_cnt  <= bit_cnt + 3'd1;
                                shift_q  <= {shift_q[6:0], 1'b0};
                                lcd_mosi <= shift_q[6];
                            end
                        end
                    end else begin
                        half_cnt <= half_cnt + 4'd1;
                    end
                end

                DONE: begin
                    gap_cnt <= 3'd0;
                    if (GAP_CYC > 3'd1) begin
                        state <= GAP;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 3'd1;
                    end
                end

                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    lcd_cs   <= 1'b1;
                    lcd_sclk <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_spi_write.sv
// Bench for lcd_spi_write: stimulus pushes expected bytes into a queue and a
// monitor decodes the SPI link and checks each byte when wr_done pulses.
module tb_lcd_spi_write;

    logic       sys_clk_50MHz = 1'b0;
    logic       sys_rst       = 1'b0;
    logic       en_write      = 1'b0;
    logic [8:0] data          = 9'h000;
    logic       wr_done, busy, lcd_sclk, lcd_mosi, lcd_dc, lcd_cs;

    lcd_spi_write dut (
        .sys_clk_50MHz (sys_clk_50MHz),
        .sys_rst       (sys_rst),
        .en_write      (en_write),
        .data          (data),
        .wr_done       (wr_done),
        .busy          (busy),
        .lcd_sclk      (lcd_sclk),
        .lcd_mosi      (lcd_mosi),
        .lcd_dc        (lcd_dc),
        .lcd_cs        (lcd_cs)
    );

    always #5 sys_clk_50MHz = ~sys_clk_50MHz;

    typedef struct packed {
        logic       dc;
        logic [7:0] b;
        logic [7:0] gap;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    endtask

    // Monitor / scoreboard
    int         cyc = 0, t_start = 0, last_done = 0, nbits = 0;
    logic [7:0] bits = 8'h00;
    logic       in_byte = 1'b0, prev_sclk = 1'b0, prev_busy = 1'b0, prev_done = 1'b0;
    exp_t       e;

    initial begin
        forever begin
            @(negedge sys_clk_50MHz);
            cyc++;
            if (sys_rst) begin
                in_byte = 1'b0;
                nbits   = 0;
            end else begin
                if (busy && !prev_busy) begin
                    in_byte = 1'b1;
                    t_start = cyc;
                    nbits   = 0;
                    bits    = 8'h00;
                end
                if (lcd_sclk && !prev_sclk) begin
                    nbits++;
                    bits = {bits[6:0], lcd_mosi};
                    check("sclk_rise_while_busy", busy, 1);
                    check("cs_low_at_sclk_rise", lcd_cs, 0);
                end
                if (prev_done) check("wr_done_one_cycle", wr_done, 0);
                if (wr_done) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_wr_done", wr_done, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("byte", bits, e.b);
                        check("dc", lcd_dc, e.dc);
                        check("sclk_rises", nbits, 8);
                        check("done_latency", cyc - t_start, 33);
                        check("cs_high_at_done", lcd_cs, 1);
                        if (e.gap != 8'd0) check("done_period", cyc - last_done, e.gap);
                    end
                    last_done = cyc;
                end
                if (!busy && prev_busy && in_byte) begin
                    check("busy_len", cyc - t_start, 35);
                    in_byte = 1'b0;
                end
            end
            prev_sclk = lcd_sclk;
            prev_busy = busy;
            prev_done = wr_done;
        end
    end

    task automatic send(input logic [8:0] d);
        @(negedge sys_clk_50MHz);
        data     = d;
        en_write = 1'b1;
        @(negedge sys_clk_50MHz);
        en_write = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge sys_clk_50MHz);
            n++;
        end
        if (n >= budget) check("idle_timeout", busy, 0);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        do begin
            @(negedge sys_clk_50MHz);
            n++;
        end while (!wr_done && n < budget);
        if (!wr_done) check("done_timeout", wr_done, 1);
    endtask

    task automatic wait_sclk_rises(input int cnt, input int budget);
        int   n = 0, r = 0;
        logic p;
        p = lcd_sclk;
        while (r < cnt && n < budget) begin
            @(negedge sys_clk_50MHz);
            n++;
            if (lcd_sclk && !p) r++;
            p = lcd_sclk;
        end
        if (r < cnt) check("sclk_timeout", r, cnt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        // Reset held for 5 clocks with idle outputs throughout
        #1 sys_rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge sys_clk_50MHz);
            check("reset_outputs", {lcd_cs, lcd_sclk, lcd_mosi, lcd_dc, wr_done, busy}, 6'b100000);
        end
        sys_rst = 1'b0;
        repeat (3) @(negedge sys_clk_50MHz);

        // Command byte and data byte
        exp_q.push_back('{dc: 1'b0, b: 8'h11, gap: 8'd0});
        send(9'h011);
        wait_idle(100);
        exp_q.push_back('{dc: 1'b1, b: 8'hA5, gap: 8'd0});
        send(9'h1A5);
        wait_idle(100);
        repeat (3) @(negedge sys_clk_50MHz);

        // Stream: upstream advances data two cycles after each wr_done
        exp_q.push_back('{dc: 1'b0, b: 8'h2A, gap: 8'd0});
        exp_q.push_back('{dc: 1'b1, b: 8'h00, gap: 8'd36});
        exp_q.push_back('{dc: 1'b1, b: 8'h9F, gap: 8'd36});
        @(negedge sys_clk_50MHz);
        data     = 9'h02A;
        en_write = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_done(100);
            @(negedge sys_clk_50MHz);
            check("cs_high_between_bytes", lcd_cs, 1);
            @(negedge sys_clk_50MHz);
            check("cs_high_before_accept", lcd_cs, 1);
            if (i == 0) data = 9'h100;
            else if (i == 1) data = 9'h19F;
            else en_write = 1'b0;
        end
        wait_idle(100);
        repeat (3) @(negedge sys_clk_50MHz);

        // Abort: reset after the 4th SCLK rise of 9'h0FF
        send(9'h0FF);
        wait_sclk_rises(4, 200);
        #2 sys_rst = 1'b1;
        #1 check("abort_async_outputs", {lcd_cs, lcd_sclk, busy, wr_done}, 4'b1000);
        repeat (2) @(negedge sys_clk_50MHz);
        sys_rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge sys_clk_50MHz);
            check("post_abort_idle", {lcd_cs, lcd_sclk, lcd_mosi, lcd_dc, wr_done, busy}, 6'b100000);
        end

        // en_write for one cycle; data changes mid-shift
        exp_q.push_back('{dc: 1'b1, b: 8'h3C, gap: 8'd0});
        send(9'h13C);
        repeat (6) @(negedge sys_clk_50MHz);
        data = 9'h000;
        wait_idle(100);
        repeat (10) @(negedge sys_clk_50MHz);
        check("stays_idle", busy, 0);
        check("stays_cs_high", lcd_cs, 1);

        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lcd_spi_write.md
LCD_SPI_WRITE -- requirements
Module: lcd_spi_write

Interface
REQ-001 SHALL have parameter SCLK_HALF, default 4'd2: system clocks per SCLK half-period (SCLK = 50 MHz / (2*SCLK_HALF) = 12.5 MHz); legal range 1..15.
REQ-002 SHALL have parameter GAP_CYC, default 3'd2: idle clocks after each wr_done before the next byte may be accepted; legal range 1..7.
REQ-003 SHALL have port sys_clk_50MHz, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-004 SHALL have port sys_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port en_write, input, 1 bit: the upstream init/draw stage requests that data be transmitted.
REQ-006 SHALL have port data, input, 9 bits: bit 8 is D/C (1 = data, 0 = command) and bits 7:0 are the payload byte.
REQ-007 SHALL have port wr_done, output, 1 bit: a one-cycle pulse when the byte has been fully shifted out.
REQ-008 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-009 SHALL have ports lcd_sclk, lcd_mosi, lcd_dc and lcd_cs, each an output of 1 bit: the SPI clock, the serial data, data/command select, and chip select (active-low).

Function
REQ-010 SHALL implement the FSM states IDLE, LOAD, SHIFT, DONE and GAP.
REQ-011 In IDLE with en_write=1, the FSM SHALL move to LOAD on the next clock; with en_write=0 it SHALL stay in IDLE.
REQ-012 LOAD SHALL last one cycle.
- Latches data into an internal 9-bit register.
- Drives lcd_cs=0, lcd_dc=data[8], lcd_mosi=data[7], lcd_sclk=0.
REQ-013 SHIFT SHALL send 8 bits MSB first. Per bit:
- lcd_sclk low for SCLK_HALF clocks, then high for SCLK_HALF clocks.
- lcd_mosi changes only at the start of a low phase and is stable across the rising edge (SPI mode 0).
REQ-014 After the high phase of bit 0, the FSM SHALL enter DONE for one cycle: lcd_sclk=0, wr_done=1, lcd_cs=1.
REQ-015 GAP SHALL hold lcd_cs=1 and lcd_sclk=0 for GAP_CYC clocks and then return to IDLE. This covers the upstream two-cycle delay between wr_done and its updated data.
REQ-016 lcd_dc SHALL hold the latched D/C value from LOAD until the next LOAD.
REQ-017 One byte SHALL take exactly 2 + 16*SCLK_HALF + GAP_CYC clocks from the IDLE cycle that accepts it to the next IDLE; with the defaults this is 36 clocks.
REQ-018 With en_write held high, wr_done SHALL pulse every 2 + 16*SCLK_HALF + GAP_CYC clocks (36 with the defaults).
REQ-019 Changes to data after LOAD SHALL have no effect on the byte in flight.
REQ-020 Deasserting en_write during LOAD, SHIFT, DONE or GAP SHALL NOT abort the byte; wr_done still pulses.
REQ-021 en_write SHALL be sampled only in IDLE.
REQ-022 The bit counter SHALL be 3 bits and the SCLK_HALF counter 4 bits; neither SHALL wrap in a way that produces extra SCLK edges.
REQ-023 Exactly 8 rising edges of lcd_sclk SHALL occur per byte.
REQ-024 All outputs SHALL be registered; there SHALL be no combinational path from input to output.

Reset
REQ-025 While sys_rst=1, the outputs SHALL immediately take these values: lcd_sclk=0, lcd_mosi=0, lcd_dc=0, lcd_cs=1, wr_done=0, busy=0.
REQ-026 While sys_rst=1, the FSM SHALL be in IDLE and all counters and the shift register SHALL be cleared.
REQ-027 Reset asserted mid-byte SHALL abandon that byte with no wr_done pulse. After release, the block SHALL wait in IDLE for en_write.

Verification
REQ-028 Reset: assert sys_rst for 5 clocks -> lcd_cs=1, lcd_sclk=0, lcd_mosi=0, lcd_dc=0, wr_done=0, busy=0 throughout.
REQ-029 Command byte: data=9'h011 with en_write pulsed once -> lcd_dc=0; mosi sampled on the 8 rising SCLK edges = 0,0,0,1,0,0,0,1; wr_done is high for 1 cycle, 34 clocks after the accepting cycle; busy is low again 36 clocks after acceptance.
REQ-030 Data byte: data=9'h1A5 -> lcd_dc=1 and sampled bits = 1,0,1,0,0,1,0,1.
REQ-031 Stream: en_write held high while a model of the upstream stage presents 9'h02A, 9'h100 and 9'h19F, each advancing 2 cycles after wr_done -> three wr_done pulses 36 clocks apart, all three bytes decoded correctly, and lcd_cs high between bytes.
REQ-032 Abort: sys_rst pulsed after the 4th rising SCLK edge of 9'h0FF -> lcd_cs=1 asynchronously; no wr_done; after release with en_write=0 the outputs stay idle for 50 clocks.
REQ-033 en_write drop: en_write=1 for one cycle only, and data changed to 9'h000 during SHIFT -> the original byte completes unchanged and wr_done pulses once; the FSM then stays in IDLE.
